// File: rtl/sigmoid_lut_loader.sv
// Runtime-loadable sigmoid lookup table: valid/ready table loader plus 2-cycle lookup pipeline.
// Define SIGMOID_CKSUM_EN to verify a 16-bit checksum of the loaded table before accepting it.
module sigmoid_lut_loader #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 10,
    parameter int SHIFT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [OUT_W-1:0]    s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    input  logic [15:0]         expected_cksum,
    output logic                table_valid,
    output logic                load_err,
    output logic [ADDR_W:0]     load_count,
    input  logic                x_valid,
    input  logic [IN_W-1:0]     x,
    output logic                y_valid,
    output logic [OUT_W-1:0]    y
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = ADDR_W + SHIFT;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic signed [IN_W:0] MAX_X = (IN_W + 1)'((2 ** (IDX_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_X = -MAX_X - 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic                ram_we;
    logic                accept;
    logic                final_beat;
    logic                cksum_ok;

    logic [OUT_W-1:0]    table_mem [DEPTH];

    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] x_clamped;
    logic [IDX_W-1:0]     x_offset;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 tag_q, tag_d;
    logic                 y_valid_q, y_valid_d;
    logic [OUT_W-1:0]     y_q, y_d;

    assign s_ready     = (state_q == LOAD);
    assign table_valid = (state_q == READY);
    assign load_err    = (state_q == ERR);
    assign load_count  = load_count_q;
    assign y_valid     = y_valid_q;
    assign y           = y_q;

    // A restart takes priority over any beat presented in the same cycle.
    assign accept     = s_valid & s_ready & ~load_start;
    assign final_beat = (load_count_q == LAST_IDX);

`ifdef SIGMOID_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;
    logic [15:0] cksum_next;

    assign cksum_next = cksum_q + 16'(s_data);
    assign cksum_ok   = (cksum_next == expected_cksum);

    always_comb begin
        cksum_d = cksum_q;
        if (load_start) begin
            cksum_d = '0;
        end else if (accept) begin
            cksum_d = cksum_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end
`else
    logic unused_cksum;
    assign unused_cksum = ^expected_cksum;
    assign cksum_ok     = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        load_count_d = load_count_q;
        ram_we       = 1'b0;
        if (load_start) begin
            state_d      = LOAD;
            wr_addr_d    = '0;
            load_count_d = '0;
        end else if (accept) begin
            ram_we       = 1'b1;
            wr_addr_d    = wr_addr_q + 1'b1;
            load_count_d = load_count_q + 1'b1;
            // An early s_last or a missing s_last on the final beat both invalidate the table.
            if (s_last || final_beat) begin
                state_d = (s_last && final_beat && cksum_ok) ? READY : ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            load_count_q <= load_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            table_mem[wr_addr_q] <= s_data;
        end
    end

    // Adding the half-range bias to an in-range two's complement value is an MSB flip.
    always_comb begin
        x_ext = {x[IN_W-1], x};
        if (x_ext > MAX_X) begin
            x_clamped = MAX_X;
        end else if (x_ext < MIN_X) begin
            x_clamped = MIN_X;
        end else begin
            x_clamped = x_ext;
        end
        x_offset = {~x_clamped[IDX_W-1], x_clamped[IDX_W-2:0]};
    end

    logic unused_bits;
    assign unused_bits = ^{x_clamped[IN_W:IDX_W], x_offset[SHIFT-1:0]};

    always_comb begin
        addr_d    = x_offset[IDX_W-1:SHIFT];
        tag_d     = x_valid & table_valid;
        y_valid_d = tag_q;
        y_d       = y_q;
        if (tag_q) begin
            y_d = table_mem[addr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            tag_q     <= 1'b0;
            y_valid_q <= 1'b0;
            y_q       <= '0;
        end else begin
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Directed self-checking bench for sigmoid_lut_loader: loads, load errors, restarts, reset and lookups.
module tb_sigmoid_lut_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [15:0] expected_cksum;
    logic        table_valid;
    logic        load_err;
    logic [10:0] load_count;
    logic        x_valid;
    logic [15:0] x;
    logic        y_valid;
    logic [15:0] y;

    int checks   = 0;
    int failures = 0;

    sigmoid_lut_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_start     (load_start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .expected_cksum (expected_cksum),
        .table_valid    (table_valid),
        .load_err       (load_err),
        .load_count     (load_count),
        .x_valid        (x_valid),
        .x              (x),
        .y_valid        (y_valid),
        .y              (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseLoadStart();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Streams n beats with word i = i; s_last rides on beat last_at (1-based, 0 = never).
    task automatic applyStimulus(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            s_last  = ((i + 1) == last_at);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic lookupOne(input string tag, input logic [15:0] xin,
                             input logic exp_v, input logic [15:0] exp_y);
        x_valid = 1'b1;
        x       = xin;
        step();
        x_valid = 1'b0;
        step();
        checkOutput({tag, "_yv"}, 32'(y_valid), 32'(exp_v));
        if (exp_v) begin
            checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        load_start     = 1'b0;
        s_data         = '0;
        s_valid        = 1'b0;
        s_last         = 1'b0;
        expected_cksum = 16'hFE00;
        x_valid        = 1'b0;
        x              = '0;
        #12;
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_table_valid", 32'(table_valid), 32'd0);
        checkOutput("rst_load_err", 32'(load_err), 32'd0);
        checkOutput("rst_load_count", 32'(load_count), 32'd0);
        checkOutput("rst_y_valid", 32'(y_valid), 32'd0);
        checkOutput("rst_y", 32'(y), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        lookupOne("nolut", 16'h0000, 1'b0, 16'h0000);
        checkOutput("nolut_tv", 32'(table_valid), 32'd0);
        checkOutput("nolut_ready", 32'(s_ready), 32'd0);

        pulseLoadStart();
        checkOutput("load_s_ready", 32'(s_ready), 32'd1);
        checkOutput("load_cnt0", 32'(load_count), 32'd0);
        applyStimulus(1024, 1024);
        checkOutput("load_tv", 32'(table_valid), 32'd1);
        checkOutput("load_cnt", 32'(load_count), 32'd1024);
        checkOutput("load_err0", 32'(load_err), 32'd0);
        checkOutput("load_done_ready", 32'(s_ready), 32'd0);

        lookupOne("x_zero", 16'h0000, 1'b1, 16'h0200);
        lookupOne("x_max", 16'h7FFF, 1'b1, 16'h03FF);
        lookupOne("x_min", 16'h8000, 1'b1, 16'h0000);
        lookupOne("x_clamp_hi", 16'h2000, 1'b1, 16'h03FF);
        lookupOne("x_edge_hi", 16'h1FFF, 1'b1, 16'h03FF);
        lookupOne("x_clamp_lo", 16'hDFFF, 1'b1, 16'h0000);
        lookupOne("x_neg16", 16'hFFF0, 1'b1, 16'h01FF);

        x_valid = 1'b1;
        x       = 16'h0010;
        step();
        x       = 16'h0020;
        step();
        x_valid = 1'b0;
        checkOutput("b2b_v0", 32'(y_valid), 32'd1);
        checkOutput("b2b_y0", 32'(y), 32'h0201);
        step();
        checkOutput("b2b_v1", 32'(y_valid), 32'd1);
        checkOutput("b2b_y1", 32'(y), 32'h0202);
        step();
        checkOutput("hold_v", 32'(y_valid), 32'd0);
        checkOutput("hold_y", 32'(y), 32'h0202);

        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        step();
        step();
        s_valid = 1'b0;
        checkOutput("idle_beats_cnt", 32'(load_count), 32'd1024);
        lookupOne("idle_beats_y", 16'h8000, 1'b1, 16'h0000);

        pulseLoadStart();
        checkOutput("early_tv_clr", 32'(table_valid), 32'd0);
        applyStimulus(500, 500);
        checkOutput("early_err", 32'(load_err), 32'd1);
        checkOutput("early_tv", 32'(table_valid), 32'd0);
        checkOutput("early_cnt", 32'(load_count), 32'd500);
        checkOutput("early_ready", 32'(s_ready), 32'd0);
        lookupOne("early_lookup", 16'h0000, 1'b0, 16'h0000);

        pulseLoadStart();
        checkOutput("errclr", 32'(load_err), 32'd0);
        applyStimulus(1024, 0);
        checkOutput("nolast_err", 32'(load_err), 32'd1);
        checkOutput("nolast_cnt", 32'(load_count), 32'd1024);

        pulseLoadStart();
        applyStimulus(300, 0);
        checkOutput("restart_cnt300", 32'(load_count), 32'd300);
        load_start = 1'b1;
        s_valid    = 1'b1;
        s_data     = 16'hDEAD;
        step();
        load_start = 1'b0;
        s_valid    = 1'b0;
        checkOutput("restart_cnt0", 32'(load_count), 32'd0);
        checkOutput("restart_ready", 32'(s_ready), 32'd1);
        applyStimulus(1024, 1024);
        checkOutput("restart_tv", 32'(table_valid), 32'd1);
        checkOutput("restart_cnt", 32'(load_count), 32'd1024);
        lookupOne("restart_y0", 16'h8000, 1'b1, 16'h0000);
        lookupOne("restart_y1", 16'h0010, 1'b1, 16'h0201);

        pulseLoadStart();
        applyStimulus(600, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(s_ready), 32'd0);
        checkOutput("midrst_tv", 32'(table_valid), 32'd0);
        checkOutput("midrst_err", 32'(load_err), 32'd0);
        checkOutput("midrst_cnt", 32'(load_count), 32'd0);
        checkOutput("midrst_yv", 32'(y_valid), 32'd0);
        checkOutput("midrst_y", 32'(y), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        lookupOne("midrst_lookup", 16'h0000, 1'b0, 16'h0000);

`ifdef SIGMOID_CKSUM_EN
        pulseLoadStart();
        applyStimulus(1024, 1024);
        checkOutput("cksum_good_tv", 32'(table_valid), 32'd1);
        expected_cksum = 16'h0000;
        pulseLoadStart();
        applyStimulus(1024, 1024);
        checkOutput("cksum_bad_err", 32'(load_err), 32'd1);
        checkOutput("cksum_bad_tv", 32'(table_valid), 32'd0);
`else
        expected_cksum = 16'h0000;
        pulseLoadStart();
        applyStimulus(1024, 1024);
        checkOutput("cksum_ignored_tv", 32'(table_valid), 32'd1);
        checkOutput("cksum_ignored_err", 32'(load_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
